// File: rtl/cordic_vectoring_atan2_if.sv
// Handshake bundle for the vectoring CORDIC: (x, y) pairs in, (angle, magnitude) out.
interface cordic_vectoring_atan2_if #(
    parameter int DATA_WIDTH_P = 32
);
    logic                           ing_valid;
    logic                           ing_ready;
    logic signed [DATA_WIDTH_P-1:0] ing_x;
    logic signed [DATA_WIDTH_P-1:0] ing_y;
    logic                           egr_valid;
    logic                           egr_ready;
    logic signed [DATA_WIDTH_P-1:0] egr_angle;
    logic signed [DATA_WIDTH_P-1:0] egr_magnitude;

    // Producer of pairs / consumer of results.
    modport master (
        output ing_valid, ing_x, ing_y, egr_ready,
        input  ing_ready, egr_valid, egr_angle, egr_magnitude
    );

    // The CORDIC core itself.
    modport slave (
        input  ing_valid, ing_x, ing_y, egr_ready,
        output ing_ready, egr_valid, egr_angle, egr_magnitude
    );
endinterface

// File: rtl/cordic_vectoring_atan2.sv
// Iterative vectoring-mode CORDIC: atan2(y, x) and sqrt(x^2 + y^2), one stage per clock.
module cordic_vectoring_atan2 #(
    parameter int DATA_WIDTH_P   = 32,
    parameter int Q_P            = 28,
    parameter int NR_OF_STAGES_P = 24
) (
    input logic clk,
    input logic rst_n,
    cordic_vectoring_atan2_if.slave bus
);
    // Two guard bits absorb the 1.647*sqrt(2) growth of a full-scale vector.
    localparam int W_INT = DATA_WIDTH_P + 2;
    localparam int PW    = W_INT + 64;
    localparam int SW    = (NR_OF_STAGES_P > 1) ? $clog2(NR_OF_STAGES_P) : 1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(NR_OF_STAGES_P - 1);

    // atan(2^-idx) in Q60; idx 0 is pi/4, the rest come from the Taylor series evaluated in Q100.
    function automatic logic [127:0] atan_q60(input int idx);
        logic [127:0] acc;
        logic [127:0] term;
        int           ex;
        acc = '0;
        if (idx == 0) begin
            acc = 128'h0C90_FDAA_2216_8C23;
        end else begin
            for (int k = 0; k < 64; k++) begin
                ex = idx * (2 * k + 1);
                if (ex <= 100) begin
                    term = (128'd1 << (100 - ex)) / 128'(2 * k + 1);
                    if ((k % 2) == 0) acc = acc + term;
                    else              acc = acc - term;
                end
            end
            acc = acc >> 40;
        end
        return acc;
    endfunction

    // 1 / prod_{j<n} sqrt(1 + 4^-j) in Q60, i.e. the inverse CORDIC gain after n stages.
    function automatic logic [63:0] gain_q60(input int n);
        logic [255:0] q;
        logic [255:0] v;
        logic [255:0] res;
        logic [255:0] t;
        logic [255:0] g;
        q = 256'd1 << 100;
        for (int j = 0; j < 32; j++) begin
            if (j < n) q = q + (q >> (2 * j));
        end
        v   = q << 100;
        res = '0;
        for (int b = 127; b >= 0; b--) begin
            t = res | (256'd1 << b);
            if (t * t <= v) res = t;
        end
        g = (256'd1 << 160) / res;
        return g[63:0];
    endfunction

    localparam logic signed [63:0]       PI_Q50   = 64'sh000C_90FD_AA22_168C;
    localparam logic signed [W_INT-1:0]  PI_INT   = W_INT'(PI_Q50 >>> (50 - Q_P));
    localparam logic signed [63:0]       GAIN_Q60 = signed'(gain_q60(NR_OF_STAGES_P));
    localparam logic signed [PW-1:0]     MAG_MAX  = (PW'(1) <<< (DATA_WIDTH_P - 1)) - PW'(1);

    typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_t;

    state_t                         state_reg, state_next;
    logic [SW-1:0]                  stage_reg;
    logic                           scale_step_reg;
    logic                           zero_reg;
    logic signed [W_INT-1:0]        x_reg, y_reg, z_reg;
    logic signed [PW-1:0]           prod_reg;
    logic signed [DATA_WIDTH_P-1:0] angle_reg, mag_reg;

    logic signed [W_INT-1:0] atan_tab [NR_OF_STAGES_P];
    logic signed [W_INT-1:0] in_x, in_y, pre_x, pre_y, pre_z;
    logic signed [W_INT-1:0] x_sh, y_sh, x_rot, y_rot, z_rot;
    logic signed [PW-1:0]    mag_full;
    logic signed [DATA_WIDTH_P-1:0] mag_sat;

    // Per-stage arctangent constants scaled from Q60 to the working Q format (truncating).
    generate
        for (genvar gi = 0; gi < NR_OF_STAGES_P; gi++) begin : g_atan
            assign atan_tab[gi] = W_INT'(atan_q60(gi) >> (60 - Q_P));
        end
    endgenerate

    // Fold the left half-plane onto the right one, seeding z with +/-pi.
    always_comb begin
        in_x  = W_INT'(bus.ing_x);
        in_y  = W_INT'(bus.ing_y);
        pre_x = in_x;
        pre_y = in_y;
        pre_z = '0;
        if (bus.ing_x[DATA_WIDTH_P-1]) begin
            pre_x = -in_x;
            pre_y = -in_y;
            pre_z = bus.ing_y[DATA_WIDTH_P-1] ? -PI_INT : PI_INT;
        end
    end

    // One micro-rotation that drives y toward zero.
    always_comb begin
        x_sh = x_reg >>> stage_reg;
        y_sh = y_reg >>> stage_reg;
        if (y_reg[W_INT-1]) begin
            x_rot = x_reg - y_sh;
            y_rot = y_reg + x_sh;
            z_rot = z_reg - atan_tab[stage_reg];
        end else begin
            x_rot = x_reg + y_sh;
            y_rot = y_reg - x_sh;
            z_rot = z_reg + atan_tab[stage_reg];
        end
    end

    // Gain-corrected magnitude, clamped to the largest positive output code.
    always_comb begin
        mag_full = prod_reg >>> 60;
        if (mag_full > MAG_MAX)       mag_sat = MAG_MAX[DATA_WIDTH_P-1:0];
        else if (mag_full[PW-1])      mag_sat = '0;
        else                          mag_sat = mag_full[DATA_WIDTH_P-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic and handshake outputs; ready is forced low while reset is held.
    always_comb begin
        state_next    = state_reg;
        bus.ing_ready = 1'b0;
        bus.egr_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.ing_ready = rst_n;
                if (bus.ing_valid) state_next = ROTATE;
            end
            ROTATE: begin
                if (stage_reg == LAST_STAGE) state_next = SCALE;
            end
            SCALE: begin
                if (scale_step_reg) state_next = DONE;
            end
            DONE: begin
                bus.egr_valid = 1'b1;
                if (bus.egr_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture, iterate, then a two-step scale (multiply, then saturate/register).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg      <= '0;
            scale_step_reg <= 1'b0;
            zero_reg       <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
            z_reg          <= '0;
            prod_reg       <= '0;
            angle_reg      <= '0;
            mag_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.ing_valid) begin
                        x_reg          <= pre_x;
                        y_reg          <= pre_y;
                        z_reg          <= pre_z;
                        zero_reg       <= (bus.ing_x == '0) && (bus.ing_y == '0);
                        stage_reg      <= '0;
                        scale_step_reg <= 1'b0;
                    end
                end
                ROTATE: begin
                    x_reg     <= x_rot;
                    y_reg     <= y_rot;
                    z_reg     <= z_rot;
                    stage_reg <= stage_reg + SW'(1);
                end
                SCALE: begin
                    if (!scale_step_reg) begin
                        prod_reg       <= PW'(x_reg) * PW'(GAIN_Q60);
                        scale_step_reg <= 1'b1;
                    end else begin
                        mag_reg   <= mag_sat;
                        // A null vector has no direction; report 0 instead of the drifted z.
                        angle_reg <= zero_reg ? '0 : DATA_WIDTH_P'(z_reg);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.egr_angle     = angle_reg;
    assign bus.egr_magnitude = mag_reg;
endmodule

// File: tb/tb_cordic_vectoring_atan2.sv
// Directed and randomised checks of the vectoring CORDIC against hand-computed values.
module tb_cordic_vectoring_atan2;
    localparam int DW = 32;
    localparam int Q  = 28;
    localparam int NS = 24;

    localparam longint ONE      = 268435456;
    localparam longint PI_Q     = 843314856;
    localparam longint PI_2_Q   = 421657428;
    localparam longint PI_4_Q   = 210828714;
    localparam longint PI_34_Q  = 632486142;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_vectoring_atan2_if #(.DATA_WIDTH_P(DW)) cv_if ();

    cordic_vectoring_atan2 #(
        .DATA_WIDTH_P  (DW),
        .Q_P           (Q),
        .NR_OF_STAGES_P(NS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (cv_if)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_result(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        tests_run++;
        if (diff > tol) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (+/- %0d)", tag, got, exp, tol);
        end
    endtask

    // Present a pair and return at the falling edge after the accepting clock edge.
    task automatic send_pair(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y, input bit keep_valid);
        int guard;
        @(negedge clk);
        cv_if.ing_x     = x;
        cv_if.ing_y     = y;
        cv_if.ing_valid = 1'b1;
        guard = 0;
        while (!cv_if.ing_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check_result("ing_ready_timeout", guard, 0, 0);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) cv_if.ing_valid = 1'b0;
    endtask

    // Wait for egr_valid (latency counted in edges after the accept), then complete the handshake.
    task automatic get_result(input bit random_bp, output longint ang, output longint mag, output int lat);
        lat = 0;
        while (!cv_if.egr_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!cv_if.egr_valid) check_result("egr_valid_timeout", lat, NS + 2, 0);
        if (random_bp) begin
            while ($urandom_range(0, 2) == 0) @(negedge clk);
        end
        ang = longint'(cv_if.egr_angle);
        mag = longint'(cv_if.egr_magnitude);
        cv_if.egr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cv_if.egr_ready = 1'b0;
    endtask

    task automatic run_directed(input string tag, input logic signed [DW-1:0] x, input logic signed [DW-1:0] y,
                                input longint exp_ang, input longint ang_tol,
                                input longint exp_mag, input longint mag_tol,
                                output longint ang);
        longint mag;
        int     lat;
        send_pair(x, y, 1'b0);
        get_result(1'b0, ang, mag, lat);
        $display("[TB] %s x=%0d y=%0d angle=%0d mag=%0d lat=%0d", tag, x, y, ang, mag, lat);
        check_result({tag, "_angle"}, ang, exp_ang, ang_tol);
        check_result({tag, "_mag"}, mag, exp_mag, mag_tol);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint ang, mag, rx, ry, exp_ang, exp_mag, mag_tol;
        int     lat;
        bit     seen_valid;
        real    r_ang, r_mag;

        cv_if.ing_valid = 1'b0;
        cv_if.ing_x     = '0;
        cv_if.ing_y     = '0;
        cv_if.egr_ready = 1'b0;

        // Reset state.
        #12;
        check_result("rst_ing_ready", cv_if.ing_ready, 0, 0);
        check_result("rst_egr_valid", cv_if.egr_valid, 0, 0);
        check_result("rst_angle", cv_if.egr_angle, 0, 0);
        check_result("rst_mag", cv_if.egr_magnitude, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_result("idle_ing_ready", cv_if.ing_ready, 1, 0);

        // (1, 1): pi/4, sqrt(2), and latency.
        send_pair(32'sh1000_0000, 32'sh1000_0000, 1'b0);
        get_result(1'b0, ang, mag, lat);
        $display("[TB] diag11 angle=%0d mag=%0d lat=%0d", ang, mag, lat);
        check_result("diag11_angle", ang, PI_4_Q, 64);
        check_result("diag11_mag", mag, 379625062, 64);
        check_result("diag11_latency", lat, NS + 2, 0);
        check_result("post_hs_valid", cv_if.egr_valid, 0, 0);
        check_result("post_hs_ready", cv_if.ing_ready, 1, 0);

        run_directed("neg_x", -32'sh1000_0000, 32'sh0, PI_Q, 64, ONE, 64, ang);
        run_directed("neg_y", 32'sh0, -32'sh1000_0000, -PI_2_Q, 64, ONE, 64, ang);
        run_directed("near_neg_pi", -32'sh1000_0000, -32'sd268, -PI_Q + 268, 64, ONE, 64, ang);
        check_result("near_neg_pi_sign", (ang < 0) ? 1 : 0, 1, 0);
        run_directed("zero", 32'sh0, 32'sh0, 0, 0, 0, 0, ang);
        run_directed("most_neg", 32'sh8000_0000, 32'sh8000_0000, -PI_34_Q, 64, 64'h7FFF_FFFF, 0, ang);

        // Backpressure with ing_valid held high and different data offered mid-computation.
        send_pair(32'sh0800_0000, -32'sh0800_0000, 1'b1);
        cv_if.ing_x = -32'sh1000_0000;
        cv_if.ing_y = 32'sh1000_0000;
        lat = 0;
        while (!cv_if.egr_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_result("hold_latency", lat, NS + 2, 0);
        check_result("hold_angle_first", cv_if.egr_angle, -PI_4_Q, 64);
        repeat (10) @(negedge clk);
        $display("[TB] hold angle=%0d mag=%0d after 10 stalled cycles", cv_if.egr_angle, cv_if.egr_magnitude);
        check_result("hold_valid", cv_if.egr_valid, 1, 0);
        check_result("hold_ing_ready", cv_if.ing_ready, 0, 0);
        check_result("hold_angle_last", cv_if.egr_angle, -PI_4_Q, 64);
        check_result("hold_mag_last", cv_if.egr_magnitude, 189812531, 64);
        cv_if.ing_valid = 1'b0;
        cv_if.egr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cv_if.egr_ready = 1'b0;
        check_result("hold_release_valid", cv_if.egr_valid, 0, 0);

        // Reset in the middle of ROTATE.
        send_pair(32'sh1000_0000, 32'sh0800_0000, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_result("midrst_ing_ready", cv_if.ing_ready, 0, 0);
        check_result("midrst_valid", cv_if.egr_valid, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_result("midrst_release_ready", cv_if.ing_ready, 1, 0);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cv_if.egr_valid) seen_valid = 1'b1;
        end
        $display("[TB] aborted pair: egr_valid seen=%0d over 40 cycles", seen_valid);
        check_result("midrst_no_result", seen_valid, 0, 0);
        run_directed("after_rst", 32'sh0C00_0000, 32'sh1000_0000, 248918915, 64, 335544320, 64, ang);

        // Random pairs under random egr_ready backpressure, checked against atan2/hypot.
        for (int n = 0; n < 150; n++) begin
            rx = longint'($urandom_range(0, 32'h8000_0000)) - 64'sh4000_0000;
            ry = longint'($urandom_range(0, 32'h8000_0000)) - 64'sh4000_0000;
            r_ang   = $atan2(real'(ry), real'(rx)) * 268435456.0;
            r_mag   = $sqrt(real'(rx) * real'(rx) + real'(ry) * real'(ry));
            exp_ang = longint'(r_ang);
            exp_mag = longint'(r_mag);
            mag_tol = longint'(r_mag / 4194304.0) + 8;
            send_pair(DW'(rx), DW'(ry), 1'b0);
            get_result(1'b1, ang, mag, lat);
            $display("[TB] rand%0d x=%0d y=%0d angle=%0d (model %0d) mag=%0d (model %0d)",
                     n, rx, ry, ang, exp_ang, mag, exp_mag);
            check_result("rand_angle", ang, exp_ang, 64);
            check_result("rand_mag", mag, exp_mag, mag_tol);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
